// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop synchronized line, half-bit start qualification.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int unsigned TIMER_W     = 16;
    localparam int unsigned BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(HALF_PERIOD);
    // Reload counts the reload cycle itself so samples are exactly BIT_PERIOD apart.
    localparam logic [TIMER_W-1:0] BIT_RELOAD = TIMER_W'(BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 sync1_q, sync2_q, line_prev_q;
    logic                 line;
    logic                 timing;
    logic                 sample_stb;
    logic                 sample_bit;

    assign line   = sync2_q;
    assign timing = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    // Input synchronizer plus edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s1_q, s0_q, pend_q;

    // Capture line at timer 1 and 0; decide one cycle later with the third sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s0_q   <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            if (timer_q == TIMER_W'(1)) s1_q <= line;
            if (timer_q == '0)          s0_q <= line;
            pend_q <= timing && (timer_q == '0);
        end
    end

    assign sample_stb = pend_q;
    assign sample_bit = (s1_q & s0_q) | (s1_q & line) | (s0_q & line);
`else
    assign sample_stb = timing && (timer_q == '0);
    assign sample_bit = line;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, bit timer and shift register
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        if (timing) begin
            timer_d = (timer_q == '0) ? BIT_RELOAD : timer_q - TIMER_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (line_prev_q && !line) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (sample_stb) begin
                    state_d = sample_bit ? IDLE : DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (sample_stb) begin
                    shift_d[idx_q] = sample_bit;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (sample_stb) state_d = sample_bit ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!((state_d == START) || (state_d == DATA) || (state_d == STOP))) begin
            timer_d = '0;
        end
    end

    // Output decode; results register on the stop-sample edge
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        if ((state_q == STOP) && sample_stb) begin
            if (sample_bit) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ferr_d  = 1'b1;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; the line is modelled as one value per clock
// and expected bytes come from sampling that waveform at bit centres.
module tb_uart_rx;

    localparam int unsigned CF = 16;
    localparam int unsigned BR = 1;
    localparam int BP = 16;
    localparam int HP = 8;
    // Raw-line index of the centre sample within each bit: half period plus synchronizer skew.
    localparam int SAMPLE_OFS = HP + 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_EXP = 9 * BP + HP + 3 + 1 + 1;
`else
    localparam int LAT_EXP = 9 * BP + HP + 3 + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.BAUD_RATE(BR), .CLOCK_FREQ(CF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int both_cnt = 0;

    bit         wave[$];
    logic [7:0] v_data[$];
    time        v_time[$];
    time        fe_time[$];
    time        t0;

    always @(negedge clk) begin
        if (rx_valid) begin
            v_data.push_back(rx_data);
            v_time.push_back($time);
        end
        if (frame_err) fe_time.push_back($time);
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vd(input int i);
        logic [7:0] r;
        r = 8'hxx;
        if (i < v_data.size()) r = v_data[i];
        return r;
    endfunction

    function automatic int vt(input int i);
        int r;
        r = -1;
        if (i < v_time.size()) r = int'(v_time[i] / 10);
        return r;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b1);
    endtask

    // One 8N1 frame; optional inverted glitch at each bit centre or at random off-centre points
    task automatic add_frame(input logic [7:0] b, input bit stop, input bit ctr_glitch, input bit rnd_glitch);
        for (int k = 0; k < 10; k++) begin
            bit bv;
            int off;
            bv  = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            off = int'($urandom_range(0, 9));
            off = (off < 6) ? off + 1 : off + 6;
            for (int c = 0; c < BP; c++) begin
                bit v;
                v = bv;
                if (ctr_glitch && c == SAMPLE_OFS) v = ~v;
                if (rnd_glitch && k >= 1 && k <= 8 && c == off) v = ~v;
                wave.push_back(v);
            end
        end
    endtask

    // Receiver view of a frame starting at wave index s: {stop, d7..d0, start}
    function automatic logic [9:0] model_frame(input int s);
        logic [9:0] bits;
        for (int k = 0; k < 10; k++) begin
            int p;
            p = s + k * BP + SAMPLE_OFS;
`ifdef UART_RX_MAJORITY_EN
            bits[k] = (int'(wave[p-1]) + int'(wave[p]) + int'(wave[p+1])) >= 2;
`else
            bits[k] = wave[p];
`endif
        end
        return bits;
    endfunction

    task automatic play();
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            rx = wave[i];
            if (i == 0) t0 = $time;
        end
        wave.delete();
    endtask

    task automatic clear_mon();
        v_data.delete();
        v_time.delete();
        fe_time.delete();
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] rb[6];
        logic [7:0] exp_d[6];
        int lat;
        bit found;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data",  32'(rx_data),   32'h00);
        chk("rst_valid", 32'(rx_valid),  32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_busy",  32'(rx_busy),   32'h0);
        rst_n = 1'b1;
        add_idle(10);
        play();
        clear_mon();

        // Single clean frame 0x55
        add_frame(8'h55, 1'b1, 1'b0, 1'b0);
        m = model_frame(0);
        add_idle(20);
        play();
        chk("f55_count", 32'(v_data.size()), 32'd1);
        chk("f55_data",  32'(vd(0)), 32'(m[8:1]));
        lat = vt(0) - int'(t0 / 10);
        chk("f55_latency", 32'((lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) ? LAT_EXP : lat), 32'(LAT_EXP));
        chk("f55_ferr",  32'(fe_time.size()), 32'd0);
        chk("f55_busy",  32'(rx_busy), 32'h0);
        clear_mon();

        // Back-to-back 0xA3, 0x0F with one stop bit each
        add_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        add_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        add_idle(20);
        play();
        chk("b2b_count", 32'(v_data.size()), 32'd2);
        chk("b2b_data0", 32'(vd(0)), 32'hA3);
        chk("b2b_data1", 32'(vd(1)), 32'h0F);
        lat = vt(1) - vt(0);
        chk("b2b_spacing", 32'((lat >= 159 && lat <= 161) ? 160 : lat), 32'd160);
        clear_mon();

        // False start: 4 low cycles only
        for (int i = 0; i < 4; i++) wave.push_back(1'b0);
        add_idle(40);
        play();
        chk("fs_valid", 32'(v_data.size()), 32'd0);
        chk("fs_ferr",  32'(fe_time.size()), 32'd0);
        chk("fs_data",  32'(rx_data), 32'h0F);
        chk("fs_busy",  32'(rx_busy), 32'h0);
        clear_mon();

        // Framing error with the line held low, then a good frame
        add_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) wave.push_back(1'b0);
        play();
        chk("fe_pulse", 32'(fe_time.size()), 32'd1);
        chk("fe_valid", 32'(v_data.size()), 32'd0);
        chk("fe_data",  32'(rx_data), 32'h0F);
        chk("fe_wait_busy", 32'(rx_busy), 32'h1);
        add_idle(5);
        play();
        chk("fe_release_busy", 32'(rx_busy), 32'h0);
        add_frame(8'h12, 1'b1, 1'b0, 1'b0);
        add_idle(20);
        play();
        chk("fe_next_count", 32'(v_data.size()), 32'd1);
        chk("fe_next_data",  32'(vd(0)), 32'h12);
        chk("fe_next_ferr",  32'(fe_time.size()), 32'd1);
        clear_mon();

        // Reset in the middle of the data bits of 0xC6
        add_frame(8'hC6, 1'b1, 1'b0, 1'b0);
        while (wave.size() > 3 * BP + 5) void'(wave.pop_back());
        play();
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk("mrst_data",  32'(rx_data),   32'h00);
        chk("mrst_valid", 32'(rx_valid),  32'h0);
        chk("mrst_ferr",  32'(frame_err), 32'h0);
        chk("mrst_busy",  32'(rx_busy),   32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        add_idle(10);
        play();
        chk("mrst_no_pulse", 32'(v_data.size() + fe_time.size()), 32'd0);
        add_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        add_idle(20);
        play();
        chk("mrst_next_count", 32'(v_data.size()), 32'd1);
        chk("mrst_next_data",  32'(vd(0)), 32'h3C);
        clear_mon();

        // Random back-to-back bytes with glitches away from the sample points
        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            add_frame(rb[i], 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            m = model_frame(i * 10 * BP);
            exp_d[i] = m[8:1];
        end
        add_idle(20);
        play();
        chk("rnd_count", 32'(v_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("rnd_data%0d", i), 32'(vd(i)), 32'(exp_d[i]));
        chk("rnd_ferr", 32'(fe_time.size()), 32'd0);
        clear_mon();

        // 0x81 with an inverted glitch at every bit centre
        add_frame(8'h81, 1'b1, 1'b1, 1'b0);
        add_idle(200);
        play();
`ifdef UART_RX_MAJORITY_EN
        chk("glitch_count", 32'(v_data.size()), 32'd1);
        chk("glitch_data",  32'(vd(0)), 32'h81);
        chk("glitch_ferr",  32'(fe_time.size()), 32'd0);
`else
        found = 1'b0;
        foreach (v_data[i]) if (v_data[i] == 8'h81) found = 1'b1;
        chk("glitch_corrupt", 32'(found), 32'd0);
`endif

        chk("valid_ferr_exclusive", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
